pipeline_elastic: RTL

PIPELINE_ELASTIC -- requirements
Module: pipeline_elastic

---
 rtl/pipeline_elastic.sv | 81 ++++++++
 1 files changed

// File: rtl/pipeline_elastic.sv
// Elastic register pipeline: DEPTH valid/data stages with per-stage stall,
// bubble collapsing, synchronous flush and an occupancy counter.
module pipeline_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] din_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    occupancy_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] free;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_d;

  assign src_valid[0] = in_valid_i;
  assign src_data[0]  = din_i;

  // A stage is free when the consumer takes the head or any stage from here
  // to the output is empty; this is the unrolled form of the free chain.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign free[gi] = out_ready_i | ~(&valid_q[DEPTH-1:gi]);

      if (gi > 0) begin : g_src
        assign src_valid[gi] = valid_q[gi-1];
        assign src_data[gi]  = data_q[gi-1];
      end

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          data_q[gi] <= '0;
        end else if (!flush_i && free[gi] && src_valid[gi]) begin
          data_q[gi] <= src_data[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (free[i]) begin
        valid_d[i] = src_valid[i];
      end
    end
    if (flush_i) begin
      valid_d = '0;
    end
    occ_d = CW'($countones(valid_d));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready_o  = free[0] & ~flush_i & rst_n_i;
  assign out_valid_o = valid_q[DEPTH-1];
  assign dout_o      = data_q[DEPTH-1];
  assign occupancy_o = occ_q;

endmodule
